// File: rtl/tdc_rr_stream_arbiter_if.sv
// Stream bundle between the per-channel TDC sources, the arbiter and the
// downstream packer: N request lanes in, one tagged beat lane out.
interface tdc_rr_stream_arbiter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int N          = 8
);
   localparam int CW = $clog2(N);

   logic [N-1:0]            s_valid;
   logic [N-1:0]            s_ready;
   logic [N*DATA_WIDTH-1:0] s_data;
   logic                    m_valid;
   logic                    m_ready;
   logic [DATA_WIDTH-1:0]   m_data;
   logic [CW-1:0]           m_chan;

   // Arbiter side: accepts the request lanes, drives the output slot.
   modport master (
      input  s_valid,
      input  s_data,
      input  m_ready,
      output s_ready,
      output m_valid,
      output m_data,
      output m_chan
   );

   // Environment side: the channel sources plus the downstream consumer.
   modport slave (
      output s_valid,
      output s_data,
      output m_ready,
      input  s_ready,
      input  m_valid,
      input  m_data,
      input  m_chan
   );
endinterface

// File: rtl/tdc_rr_stream_arbiter.sv
// Round-robin N-to-1 stream arbiter for the TDC event channel, bounded bursts.
// Optional TDC_ARB_BEATCNT_EN adds a saturating 32-bit beat_total counter.
module tdc_rr_stream_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int N          = 8,
   parameter int MAX_BURST  = 4
) (
   input  logic        clk,
   input  logic        resetn,
`ifdef TDC_ARB_BEATCNT_EN
   output logic [31:0] beat_total,
`endif
   tdc_rr_stream_arbiter_if.master bus
);

   localparam int CW = $clog2(N);
   localparam int BW = $clog2(MAX_BURST + 1);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

   localparam logic [CW:0]   N_EXT   = (CW + 1)'(N);
   localparam logic [CW-1:0] LAST_CH = CW'(N - 1);
   localparam logic [BW-1:0] LAST_BC = BW'(MAX_BURST - 1);

   logic [0:0]            state;
   logic [CW-1:0]         g;
   logic [CW-1:0]         ptr;
   logic [BW-1:0]         bc;
   logic                  m_valid_q;
   logic [DATA_WIDTH-1:0] m_data_q;
   logic [CW-1:0]         m_chan_q;

   logic [2*N-1:0]        req_dbl;
   logic [N-1:0]          req_rot;
   logic                  any_req;
   logic [CW-1:0]         off;
   logic [CW:0]           pick_sum;
   logic [CW-1:0]         pick;

   logic                  sel_valid;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  slot_free;
   logic                  xfer;
   logic                  last_beat;
   logic [CW-1:0]         nxt_ptr;

   // Rotate requests so the search always starts at ptr, then map the
   // winning offset back to an absolute channel index modulo N.
   always_comb begin
      req_dbl = {bus.s_valid, bus.s_valid} >> ptr;
      req_rot = req_dbl[N-1:0];
      any_req = 1'b0;
      off     = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req_rot[k]) begin
            any_req = 1'b1;
            off     = CW'(k);
         end
      end
      pick_sum = {1'b0, ptr} + {1'b0, off};
      if (pick_sum >= N_EXT) begin
         pick_sum = pick_sum - N_EXT;
      end
      pick = pick_sum[CW-1:0];
   end

   // Select the granted lane's valid and payload.
   always_comb begin
      sel_valid = 1'b0;
      sel_data  = '0;
      for (int i = 0; i < N; i++) begin
         if (g == CW'(i)) begin
            sel_valid = bus.s_valid[i];
            sel_data  = bus.s_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Handshake terms; the slot refills in the same cycle it drains.
   always_comb begin
      slot_free = !m_valid_q || bus.m_ready;
      xfer      = (state == ST_GRANT) && sel_valid && slot_free;
      last_beat = (bc == LAST_BC);
      nxt_ptr   = (g == LAST_CH) ? '0 : g + CW'(1);
   end

   // Only the granted lane may see ready, and only when the slot can take it.
   always_comb begin
      bus.s_ready = '0;
      for (int i = 0; i < N; i++) begin
         if ((state == ST_GRANT) && (g == CW'(i))) begin
            bus.s_ready[i] = slot_free;
         end
      end
   end

   // Grant FSM: pick in IDLE, hold for up to MAX_BURST beats or until the
   // granted lane goes idle, then advance the round-robin pointer.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= ST_IDLE;
         g     <= '0;
         ptr   <= '0;
         bc    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (any_req) begin
                  g     <= pick;
                  bc    <= '0;
                  state <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (xfer) begin
                  bc <= bc + BW'(1);
                  if (last_beat) begin
                     state <= ST_IDLE;
                     ptr   <= nxt_ptr;
                  end
               end else if (!sel_valid) begin
                  state <= ST_IDLE;
                  ptr   <= nxt_ptr;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Output slot: load on transfer, drain on downstream accept, else hold.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         m_chan_q  <= '0;
      end else if (xfer) begin
         m_valid_q <= 1'b1;
         m_data_q  <= sel_data;
         m_chan_q  <= g;
      end else if (bus.m_ready) begin
         m_valid_q <= 1'b0;
      end
   end

   assign bus.m_valid = m_valid_q;
   assign bus.m_data  = m_data_q;
   assign bus.m_chan  = m_chan_q;

`ifdef TDC_ARB_BEATCNT_EN
   // Count delivered beats; sticks at all-ones rather than wrapping.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         beat_total <= '0;
      end else if (m_valid_q && bus.m_ready && (beat_total != 32'hFFFF_FFFF)) begin
         beat_total <= beat_total + 32'd1;
      end
   end
`endif

endmodule
